// File: rtl/pcm_to_i2s_pkg.sv
// Purpose : shared constants, state encoding and width helper for the I2S transmitter.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package pcm_to_i2s_pkg;

  // PCM sample width per channel, shared with the receiver side.
  localparam int NUMBER_OF_BITS = 8;
  localparam int SLOT_BITS_DEF  = 16;
  localparam int CLK_DIV_DEF    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter width for a modulo-n counter; never narrower than one bit so that
  // CLK_DIV=1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int P_W_DEF   = cnt_width(2 * SLOT_BITS_DEF);
  localparam int DIV_W_DEF = cnt_width(CLK_DIV_DEF);

endpackage

// File: rtl/pcm_to_i2s_clock_gen.sv
// Purpose : bclk / ws / bit-position generator for the I2S transmitter.
// Latency : bclk toggles every CLK_DIV clk; strobes are combinational for the current clk.
// Backpr. : none; runs freely while i_run=1, held at zero otherwise.
// Ports   : i_run (FSM in RUN), o_bclk, o_ws (registered), o_p_next (bit position after
//           the pending fall), o_fall_strobe (this clk drops bclk), o_frame_wrap (fall that wraps p).
module pcm_to_i2s_clock_gen
  import pcm_to_i2s_pkg::*;
#(
  parameter  int SLOT_BITS = SLOT_BITS_DEF,
  parameter  int CLK_DIV   = CLK_DIV_DEF,
  localparam int P_W       = cnt_width(2 * SLOT_BITS),
  localparam int DIV_W     = cnt_width(CLK_DIV)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_run,
  output logic           o_bclk,
  output logic           o_ws,
  output logic [P_W-1:0] o_p_next,
  output logic           o_fall_strobe,
  output logic           o_frame_wrap
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic             r_ws;
  logic [P_W-1:0]   r_p;

  logic             w_tc;
  logic             w_fall;
  logic             w_wrap;
  logic [P_W-1:0]   w_p_next;

  assign w_tc     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_fall   = i_run & w_tc & r_bclk;
  assign w_wrap   = w_fall & (r_p == P_W'(2 * SLOT_BITS - 1));
  assign w_p_next = w_wrap ? '0 : (r_p + P_W'(1));

  // Leaving RUN always happens on a wrap, where every counter lands on zero by
  // itself; forcing zeros while idle also makes the next frame start clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_ws      <= 1'b0;
      r_p       <= '0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_ws      <= 1'b0;
      r_p       <= '0;
    end else begin
      if (w_tc) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_fall) begin
        r_p  <= w_p_next;
        r_ws <= (w_p_next >= P_W'(SLOT_BITS));
      end
    end
  end

  assign o_bclk        = r_bclk;
  assign o_ws          = r_ws;
  assign o_p_next      = w_p_next;
  assign o_fall_strobe = w_fall;
  assign o_frame_wrap  = w_wrap;

endmodule

// File: rtl/pcm_to_i2s.sv
// Purpose : stereo PCM to Philips I2S serialiser with its own bclk/ws generation.
// Latency : a sample accepted before frame start k is sent from p=1 of frame k.
// Backpr. : in_ready low while the single holding register is full; frees one clk after frame-start load.
// Ports   : clk, reset (async, high), enable; in_valid/in_ready/in_left/in_right sample
//           handshake; bclk, ws, sd I2S outputs; underrun one-clk pulse on empty frame start.
module pcm_to_i2s
  import pcm_to_i2s_pkg::*;
#(
  parameter  int SLOT_BITS = SLOT_BITS_DEF,
  parameter  int CLK_DIV   = CLK_DIV_DEF,
  localparam int P_W       = cnt_width(2 * SLOT_BITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  output logic                      bclk,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_frame_start;
  logic                      w_run;

  logic                      r_hold_empty;
  logic [NUMBER_OF_BITS-1:0] r_hold_l;
  logic [NUMBER_OF_BITS-1:0] r_hold_r;
  logic [NUMBER_OF_BITS-1:0] r_shadow_l;
  logic [NUMBER_OF_BITS-1:0] r_shadow_r;
  logic                      r_underrun;
  logic                      r_sd;

  logic                      w_accept;
  logic                      w_sd_bit;
  logic                      w_fall;
  logic                      w_wrap;
  logic [P_W-1:0]            w_p_next;

  assign w_run = (r_state == ST_RUN);

  pcm_to_i2s_clock_gen #(
    .SLOT_BITS (SLOT_BITS),
    .CLK_DIV   (CLK_DIV)
  ) u_clock_gen (
    .clk           (clk),
    .reset         (reset),
    .i_run         (w_run),
    .o_bclk        (bclk),
    .o_ws          (ws),
    .o_p_next      (w_p_next),
    .o_fall_strobe (w_fall),
    .o_frame_wrap  (w_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Enable is only honoured at frame boundaries once running, so a frame is
  // never cut short.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next  = ST_RUN;
          w_frame_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_wrap) begin
          if (enable) w_frame_start = 1'b1;
          else        w_state_next  = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid & r_hold_empty;

  // A frame start reads the holding register as it was before this clk, so a
  // sample accepted in the same clk (holding was empty) waits for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_empty <= 1'b1;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_shadow_l   <= '0;
      r_shadow_r   <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= w_frame_start & r_hold_empty;
      if (w_frame_start) begin
        r_shadow_l <= r_hold_empty ? '0 : r_hold_l;
        r_shadow_r <= r_hold_empty ? '0 : r_hold_r;
      end
      if (w_accept) begin
        r_hold_l <= in_left;
        r_hold_r <= in_right;
      end
      if (w_accept)           r_hold_empty <= 1'b0;
      else if (w_frame_start) r_hold_empty <= 1'b1;
    end
  end

  // Bit for the position bclk is about to enter: MSB one slot after ws changes.
  always_comb begin
    w_sd_bit = 1'b0;
    for (int i = 0; i < NUMBER_OF_BITS; i++) begin
      if (w_p_next == P_W'(i + 1))             w_sd_bit = r_shadow_l[NUMBER_OF_BITS-1-i];
      if (w_p_next == P_W'(SLOT_BITS + i + 1)) w_sd_bit = r_shadow_r[NUMBER_OF_BITS-1-i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_sd <= 1'b0;
    else if (!w_run) r_sd <= 1'b0;
    else if (w_fall) r_sd <= w_sd_bit;
  end

  assign sd       = r_sd;
  assign underrun = r_underrun;
  assign in_ready = r_hold_empty;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Purpose : self-checking bench for pcm_to_i2s against a time-based frame model.
// Latency : model derives bclk/ws/sd from clk count since frame start.
// Backpr. : model keeps a one-entry holding slot to predict in_ready/underrun.
module tb_pcm_to_i2s;
  import pcm_to_i2s_pkg::*;

  localparam int N     = NUMBER_OF_BITS;
  localparam int S     = 16;
  localparam int CD    = 2;
  localparam int BIT   = 2 * CD;
  localparam int FRAME = 4 * S * CD;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_left;
  logic [N-1:0] in_right;
  logic         bclk;
  logic         ws;
  logic         sd;
  logic         underrun;

  always #5 clk = ~clk;

  pcm_to_i2s #(.SLOT_BITS(S), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_left  (in_left),
    .in_right (in_right),
    .bclk     (bclk),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: running flag, clk count within the current frame, a
  // one-entry holding slot and the sample pair of the frame being sent.
  bit           m_run;
  int           m_n;
  bit           m_hold_full;
  logic [N-1:0] m_hold_l, m_hold_r;
  logic [N-1:0] m_cur_l, m_cur_r;
  bit           m_udr;
  bit           m_last_acc;
  bit [1:24]    pat;

  function automatic int m_p();
    return (m_n / BIT) % (2 * S);
  endfunction

  task automatic model_reset();
    m_run = 0; m_n = 0; m_hold_full = 0; m_udr = 0;
    m_hold_l = '0; m_hold_r = '0; m_cur_l = '0; m_cur_r = '0;
  endtask

  task automatic frame_start();
    if (m_hold_full) begin
      m_cur_l = m_hold_l; m_cur_r = m_hold_r; m_hold_full = 0;
    end else begin
      m_cur_l = '0; m_cur_r = '0; m_udr = 1;
    end
  endtask

  task automatic compare();
    int p;
    logic e_bclk, e_ws, e_sd;
    p      = m_p();
    e_bclk = m_run && ((m_n / CD) % 2 == 1);
    e_ws   = m_run && (p >= S);
    e_sd   = 1'b0;
    if (m_run) begin
      if (p >= 1 && p <= N)              e_sd = m_cur_l[N-p];
      else if (p >= S + 1 && p <= S + N) e_sd = m_cur_r[N-(p-S)];
    end
    check_eq("bclk", bclk, e_bclk);
    check_eq("ws", ws, e_ws);
    check_eq("sd", sd, e_sd);
    check_eq("in_ready", in_ready, !m_hold_full);
    check_eq("underrun", underrun, m_udr);
  endtask

  task automatic step();
    bit acc;
    acc = in_valid && !m_hold_full && !reset;
    @(posedge clk);
    if (reset) begin
      model_reset();
      acc = 0;
    end else begin
      m_udr = 0;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_n = 0; frame_start(); end
      end else begin
        m_n++;
        if (m_n == FRAME) begin
          m_n = 0;
          if (enable) frame_start();
          else        m_run = 0;
        end
      end
      if (acc) begin m_hold_full = 1; m_hold_l = in_left; m_hold_r = in_right; end
    end
    m_last_acc = acc;
    #1;
    compare();
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
  endtask

  initial begin
    int  d;
    bit  found;
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    pat = {8'hA5, 8'h00, 8'h3C};
    #1;
    model_reset();
    compare();
    repeat (3) step();
    reset = 1'b0;
    step();

    // Preload A5/3C, then enable; also check the literal bit pattern at rising bclk.
    in_valid = 1'b1; in_left = 8'hA5; in_right = 8'h3C;
    step();
    in_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (m_run && (m_n % BIT == CD) && m_p() >= 1 && m_p() <= 24)
        check_eq($sformatf("a5_p%0d", m_p()), sd, pat[m_p()]);
    end
    repeat (20) step();

    // Streaming with incrementing data.
    d = 1;
    in_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      in_left = N'(d); in_right = ~N'(d);
      step();
      if (m_last_acc) d++;
    end
    in_valid = 1'b0;

    // Drop enable at p=5; holding sample retained across IDLE.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_run && m_p() == 5) found = 1; else step();
    end
    check_eq("wait_p5", found, 1);
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < FRAME + 8 && !found; i++) begin
      step();
      if (!m_run) found = 1;
    end
    check_eq("wait_idle", found, 1);
    repeat (20) step();
    enable = 1'b1;
    repeat (FRAME + 10) step();

    // Accept in the same clk as the frame-start load.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_run && m_n == FRAME - 1) found = 1; else step();
    end
    check_eq("wait_wrap", found, 1);
    in_valid = 1'b1; in_left = 8'h5A; in_right = 8'hC3;
    step();
    check_eq("same_clk_underrun", underrun, 1);
    in_valid = 1'b0;
    repeat (2 * FRAME) step();

    // Asynchronous reset in the right slot.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_run && m_p() == 20) found = 1; else step();
    end
    check_eq("wait_p20", found, 1);
    async_reset_check();
    repeat (2) step();
    reset = 1'b0;
    repeat (40) step();
    in_valid = 1'b1; in_left = N'($urandom); in_right = N'($urandom);
    step();
    in_valid = 1'b0;
    repeat (2 * FRAME) step();

    // Randomized traffic with occasional enable toggles.
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_left  = N'($urandom);
      in_right = N'($urandom);
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pcm_to_i2s.md
Name: pcm_to_i2s

Overview:
I2S transmitter, the output-side counterpart of the I2S-to-PCM receiver. Accepts stereo PCM sample pairs over a valid/ready handshake and serialises them MSB-first as standard Philips I2S. It generates its own bit clock (bclk) and word select (ws) from clk. It drives external DACs or loops back into the receiver path for test.

Parameters:
NUMBER_OF_BITS, 8, PCM sample width per channel (shared package constant).
SLOT_BITS, 16, bclk periods per channel slot; must be >= NUMBER_OF_BITS+1.
CLK_DIV, 2, clk cycles per bclk half-period; must be >= 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; sampled on clk
in_valid  in  1  sample pair valid
in_ready  out  1  holding register empty; transfer on in_valid & in_ready
in_left  in  NUMBER_OF_BITS  left PCM sample, two's complement
in_right  in  NUMBER_OF_BITS  right PCM sample, two's complement
bclk  out  1  I2S bit clock, period 2*CLK_DIV clk cycles
ws  out  1  word select; 0 = left, 1 = right
sd  out  1  serial data; changes only on falling bclk
underrun  out  1  one-clk pulse when a frame starts with the holding register empty

Behaviour:
- Reset (async): state IDLE; bclk=0, ws=0, sd=0, underrun=0, in_ready=1; holding and shadow registers cleared, flagged empty; div_cnt=0; bit position p=0.
- States: IDLE, RUN. Every output is registered.
- IDLE: bclk, ws and sd held at 0. On a clk edge with enable=1, go to RUN and perform a frame start: p=0, shadow <= holding, div_cnt=0.
- RUN: div_cnt counts 0..CLK_DIV-1. At terminal count bclk toggles and div_cnt wraps.
- On each falling bclk toggle, p advances modulo 2*SLOT_BITS; ws and sd update in that same clk cycle.
- ws = 0 for p in 0..SLOT_BITS-1; ws = 1 for p in SLOT_BITS..2*SLOT_BITS-1.
- sd = left[NUMBER_OF_BITS-p] for p = 1..NUMBER_OF_BITS, so the MSB appears one bit after ws falls.
- sd = right[NUMBER_OF_BITS-(p-SLOT_BITS)] for p = SLOT_BITS+1..SLOT_BITS+NUMBER_OF_BITS.
- sd = 0 at all other p, including p=0 and p=SLOT_BITS.
- Frame start occurs when p wraps from 2*SLOT_BITS-1 to 0: shadow <= holding and holding is marked empty.
- Underrun: if holding is empty at frame start, the shadow is loaded with zeros and underrun pulses for 1 clk.
- Handshake:
  - in_ready = holding empty.
  - When in_valid & in_ready, capture in_left/in_right; in_ready=0 from the next clk.
  - in_ready returns to 1 on the clk after the frame-start load.
  - in_valid is accepted in IDLE too, so a sample can be preloaded before enable.
  - Simultaneous accept and frame-start load: the load takes the old holding contents (or underrun), and the new sample stays in holding.
- enable deasserted in RUN: the current frame completes. At the falling bclk that would wrap p to 0, go to IDLE with bclk=0, ws=0, sd=0; no load occurs and holding is retained.
- enable re-asserted on that same wrap edge: stay in RUN and do a normal frame start.
- Latency: a sample accepted before frame start k appears at p=1 of frame k. Frame length is 4*SLOT_BITS*CLK_DIV clk cycles (128 at defaults).
- Reset mid-frame: immediate return to reset values; no partial bits are emitted after reset deasserts.

Decomposition:
- Shared package (parameters file):
  - NUMBER_OF_BITS
  - default SLOT_BITS
  - state encoding IDLE/RUN
  - width localparams: $clog2(2*SLOT_BITS) for p, $clog2(CLK_DIV) for div_cnt
- Natural sub-module: i2s_clock_gen, holding div_cnt, bclk, p and ws. It outputs a one-clk fall_strobe and a frame_wrap strobe.
- The top level holds the holding/shadow registers, the handshake, the FSM and sd selection.

Test Plan:
- Preload left=0xA5, right=0x3C, then enable, with defaults N=8, S=16, CLK_DIV=2.
  - On rising bclk, sd at p=1..8 = 1,0,1,0,0,1,0,1; p=9..16 = 0; ws rises at p=16.
  - p=17..24 = 0,0,1,1,1,1,0,0.
  - bclk period is 4 clk; frame is 128 clk.
- in_valid held high with incrementing data 0x01,0x02,...: in_ready is high for exactly one clk per 128-clk frame; frame k carries sample k with no gaps and underrun never pulses.
- Enable with no sample supplied: underrun pulses at the first frame start and sd stays 0 all frame; a sample pushed mid-frame appears in the next frame with no further underrun.
- Drop enable at p=5: the frame completes through p=31, then bclk=ws=sd=0 in IDLE; the holding sample is retained and sent first after re-enable.
- Assert reset at p=20 in the right slot: bclk, ws, sd and underrun are 0 and in_ready=1 in the same cycle (async); after release with enable=1 the first frame starts cleanly at p=0.
- Accept a sample in the same clk as the frame-start load: old data (or zeros plus underrun) is transmitted, and the new sample follows in the next frame.
